aes_round_ctrl: RTL
===================

# aes_round_ctrl

Sequencing controller for the AES-128 encryption datapath. On a `load` rising edge it runs the initial AddRoundKey and NR cipher rounds. Each round takes two cycles: an S-box read cycle, then a commit cycle through SubBytes, ShiftRows, MixColumns and AddRoundKey. The block drives all datapath and key-expansion enables and the round constant, then reports completion on `done`. It sits inside the AES core between the SPI load/done handshake and the round datapath.

## Interface
- `NR`, default 10: number of cipher rounds; the final round omits MixColumns.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `load` input 1: level from the SPI side; a 0→1 transition starts an encryption.
- `busy` output 1: high from INIT through the final ROUND.
- `done` output 1: high in DONE; holds until the next accepted start or reset.
- `sel_init` output 1: selects `plaintext ^ key` into the state register (INIT only).
- `state_en` output 1: state register write enable.
- `sub_req` output 1: synchronous S-box read request for the state and key words.
- `shift_en` output 1: ShiftRows enable; high in ROUND.
- `mix_en` output 1: MixColumns enable; high in ROUND when `round < NR`.
- `key_en` output 1: round-key register update enable.
- `rcon` output 8: round constant for the current round.
- `round` output 4: current round number, 0..NR.

## Operation
- States: IDLE, INIT, SUB, ROUND, DONE.
- `load` is registered once. `start = load & ~load_q`.
- IDLE or DONE with `start` → INIT. In INIT: `round=0`, `rcon=8'h01`, `sel_init=1`, `state_en=1`, `key_en=1` (loads the cipher key). Next state is SUB with `round=1`.
- SUB: `sub_req=1`; all other enables are 0. Next state is ROUND.
- ROUND: `state_en=1`, `shift_en=1`, `key_en=1`, `mix_en=(round!=NR)`.
  - If `round==NR`, go to DONE.
  - Otherwise increment `round`, set `rcon<=xtime(rcon)`, and go to SUB.
- `xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00)`. The sequence for rounds 1..10 is 01,02,04,08,10,20,40,80,1B,36.
- DONE: `done=1`; all enables are 0; `round` and `rcon` hold their values.
- `start` while `busy` is ignored. A `load` fall while busy is ignored.
- `load` held high across DONE does not restart; a fresh 0→1 edge is required.

## Timing
- Reset (async assert, sync deassert internally): state IDLE; `load_q=0`; `round=0`; `rcon=8'h01`; every output 0.
- Let cycle 0 be the edge at which `start` is sampled. The controller is in INIT at cycle 1.
- SUB for round r occupies cycle 2r. ROUND for round r occupies cycle 2r+1.
- The final ROUND is at cycle 2NR+1 (21 for NR=10). `done` rises at cycle 2NR+2 (22).
- `busy` is high for exactly 2NR+1 cycles.
- All outputs are Moore outputs decoded from registered state; there is no combinational path from `load`.
- Reset asserted mid-operation: outputs clear immediately. No partial `done` is produced.
- `start` in the same cycle that DONE is entered is not seen, because DONE is entered from ROUND, not IDLE.

## Structure
- `aes_pkg` holds:
  - the `ctrl_state_t` enum;
  - `RCON_INIT = 8'h01` and `RCON_POLY = 8'h1B`;
  - the `xtime` function, which is shared with MixColumns.
- One sub-module, `rcon_gen`: 8-bit register with load-to-01 and advance inputs, using `xtime`.
- The FSM and round counter stay in `aes_round_ctrl`.

## Test plan
- Reset, then a `load` pulse: INIT at cycle 1; `round` steps 1..10; `rcon` trace is 01,02,04,08,10,20,40,80,1B,36; `done` rises at cycle 22 and `busy` is high for 21 cycles.
- `mix_en` check: high in ROUND for rounds 1..9, low in round 10, and never high in SUB, INIT or DONE.
- Second `load` edge at cycle 8: ignored; the sequence and `done` timing are unchanged.
- `load` held high through DONE, then dropped and re-raised: exactly one new run starts, and `done` falls in the INIT cycle.
- `reset_n` asserted at cycle 11: all outputs are 0 that cycle. After release, a new `load` gives the full 22-cycle run with `rcon` restarting at 01.
- With the datapath attached, FIPS-197 C.1 vector: key 000102..0f, plaintext 00112233..eeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a on `done`.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, round-constant values
// and the GF(2^8) xtime helper used by both the key schedule and MixColumns.
`default_nettype none

package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SUB   = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;
  localparam int unsigned ROUND_W  = 4;

  // Multiply by x in GF(2^8), reducing modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_ctrl_rcon_gen.sv
// Round-constant register: reloads to 01 at the start of a run and steps
// through xtime once per completed non-final round.
`default_nettype none

module rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_i,
  input  logic       advance_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (init_i) begin
      rcon_d = RCON_INIT;
    end else if (advance_i) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcon_q <= RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;

endmodule

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: INIT, then NR pairs of S-box read (SUB) and commit
// (ROUND) cycles, then DONE. All outputs are registered Moore outputs.
`default_nettype none

module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic                sel_init,
  output logic                state_en,
  output logic                sub_req,
  output logic                shift_en,
  output logic                mix_en,
  output logic                key_en,
  output logic [7:0]          rcon,
  output logic [ROUND_W-1:0]  round
);

  localparam logic [ROUND_W-1:0] NR_L = ROUND_W'(NR);

  logic [1:0]         rst_sync_q;
  logic               rst_n_int;
  ctrl_state_t        state_q;
  logic               load_q;
  logic [ROUND_W-1:0] round_q;
  logic               busy_q;
  logic               done_q;
  logic               sel_init_q;
  logic               state_en_q;
  logic               sub_req_q;
  logic               shift_en_q;
  logic               mix_en_q;
  logic               key_en_q;
  logic               start;
  logic               accept;
  logic               rcon_adv;

  // Reset asserts asynchronously but releases only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  assign start    = load & ~load_q;
  assign accept   = start & ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign rcon_adv = (state_q == ST_ROUND) && (round_q != NR_L);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= ST_IDLE;
      load_q     <= 1'b0;
      round_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_init_q <= 1'b0;
      state_en_q <= 1'b0;
      sub_req_q  <= 1'b0;
      shift_en_q <= 1'b0;
      mix_en_q   <= 1'b0;
      key_en_q   <= 1'b0;
    end else begin
      load_q     <= load;
      sel_init_q <= 1'b0;
      state_en_q <= 1'b0;
      sub_req_q  <= 1'b0;
      shift_en_q <= 1'b0;
      mix_en_q   <= 1'b0;
      key_en_q   <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_q    <= ST_INIT;
            round_q    <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            sel_init_q <= 1'b1;
            state_en_q <= 1'b1;
            key_en_q   <= 1'b1;
          end
        end
        ST_INIT: begin
          state_q   <= ST_SUB;
          round_q   <= ROUND_W'(1);
          sub_req_q <= 1'b1;
        end
        ST_SUB: begin
          state_q    <= ST_ROUND;
          state_en_q <= 1'b1;
          shift_en_q <= 1'b1;
          key_en_q   <= 1'b1;
          mix_en_q   <= (round_q != NR_L);
        end
        ST_ROUND: begin
          if (round_q == NR_L) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= ST_SUB;
            round_q   <= round_q + ROUND_W'(1);
            sub_req_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  rcon_gen u_rcon_gen (
    .clk       (clk),
    .reset_n   (rst_n_int),
    .init_i    (accept),
    .advance_i (rcon_adv),
    .rcon_o    (rcon)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign sel_init = sel_init_q;
  assign state_en = state_en_q;
  assign sub_req  = sub_req_q;
  assign shift_en = shift_en_q;
  assign mix_en   = mix_en_q;
  assign key_en   = key_en_q;
  assign round    = round_q;

endmodule

`default_nettype wire
